if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID stage.
- Holds the PC and the internal instruction memory, with a program-load write port.
- Computes next-PC from the ID-stage redirects (branch via pc_src, jump) and the hazard unit's stall.
- Drives the IF/ID pipeline register: instruction and PC+4 consumed by ID.

---
 rtl/if_stage_pkg.sv | 14 +
 rtl/if_imem.sv | 31 +++
 rtl/if_stage.sv | 98 +++++++++
 tb/tb_if_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Pipeline-wide constants shared by the fetch stage and its instruction memory.
package if_stage_pkg;

    localparam int          DATA_W     = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP    = 32'd4;

    // True when the fetched word is the halt sentinel.
    function automatic logic is_halt(input logic [DATA_W-1:0] instr);
        return instr == HALT_INSTR;
    endfunction

endpackage

// File: rtl/if_imem.sv
// Instruction memory: word array with asynchronous read and synchronous write.
// Contents are never cleared by reset so a loaded program survives it.
module if_imem
    import if_stage_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int IMEM_AW    = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IMEM_AW-1:0]  wr_idx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [IMEM_AW-1:0]  rd_idx,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [IMEM_DEPTH];

    // Program-load write port; a same-cycle read still returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wdata;
        end
    end

    // Combinational fetch read.
    always_comb begin
        rdata = mem[rd_idx];
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (stall, jump,
// branch, halt) and the IF/ID pipeline register feeding decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int IMEM_AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_addr,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    input  logic        imem_we,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus_4,
    output logic [31:0] pc,
    output logic        halted
);

    logic [DATA_W-1:0] fetched;
    logic [31:0]       pc_plus_4;
    logic [31:0]       pc_next;
    logic [31:0]       instr_next;
    logic [31:0]       pc4_next;
    logic              halted_next;
    logic              unused_addr_bits;

    // Only the word index of the load address matters; the rest is dropped.
    assign unused_addr_bits = ^{imem_addr[31:IMEM_AW+2], imem_addr[1:0]};

    if_imem #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .IMEM_AW    (IMEM_AW)
    ) u_imem (
        .clk    (clk),
        .we     (imem_we),
        .wr_idx (imem_addr[IMEM_AW+1:2]),
        .wdata  (imem_wdata),
        .rd_idx (pc[IMEM_AW+1:2]),
        .rdata  (fetched)
    );

    assign pc_plus_4 = pc + PC_STEP;

    // Next-state selection in priority order: freeze, halted, stall, jump, branch, halt fetch, advance.
    always_comb begin
        pc_next     = pc;
        instr_next  = if_id_instruction;
        pc4_next    = if_id_pc_plus_4;
        halted_next = halted;
        if (!enable) begin
            // Whole stage frozen for debug or program load.
        end else if (halted) begin
            instr_next = NOP_INSTR;
            pc4_next   = '0;
        end else if (stall) begin
            // Redirects are dropped here; decode re-presents them after the stall.
        end else if (jump) begin
            pc_next    = jump_addr;
            instr_next = NOP_INSTR;
            pc4_next   = '0;
        end else if (pc_src) begin
            pc_next    = branch_addr;
            instr_next = NOP_INSTR;
            pc4_next   = '0;
        end else if (is_halt(fetched)) begin
            instr_next  = HALT_INSTR;
            pc4_next    = pc_plus_4;
            halted_next = 1'b1;
        end else begin
            pc_next    = pc_plus_4;
            instr_next = fetched;
            pc4_next   = pc_plus_4;
        end
    end

    // PC, IF/ID register and halt flag; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc                <= '0;
            if_id_instruction <= NOP_INSTR;
            if_id_pc_plus_4   <= '0;
            halted            <= 1'b0;
        end else begin
            pc                <= pc_next;
            if_id_instruction <= instr_next;
            if_id_pc_plus_4   <= pc4_next;
            halted            <= halted_next;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for the fetch stage with hand-computed expectations.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_addr;
    logic        jump;
    logic [31:0] jump_addr;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus_4;
    logic [31:0] pc;
    logic        halted;

    int n_chk;
    int n_pass;

    if_stage #(
        .IMEM_DEPTH (256),
        .IMEM_AW    (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .stall             (stall),
        .pc_src            (pc_src),
        .branch_addr       (branch_addr),
        .jump              (jump),
        .jump_addr         (jump_addr),
        .imem_we           (imem_we),
        .imem_addr         (imem_addr),
        .imem_wdata        (imem_wdata),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus_4   (if_id_pc_plus_4),
        .pc                (pc),
        .halted            (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4, input logic [31:0] p);
        chk({tag, "_instr"}, if_id_instruction, ins);
        chk({tag, "_pc4"},   if_id_pc_plus_4,   p4);
        chk({tag, "_pc"},    pc,                p);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_addr  = addr;
        imem_wdata = data;
        step();
        imem_we    = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        stall       = 1'b0;
        pc_src      = 1'b0;
        branch_addr = '0;
        jump        = 1'b0;
        jump_addr   = '0;
        imem_we     = 1'b0;
        imem_addr   = '0;
        imem_wdata  = '0;

        // Reset for two edges.
        step();
        step();
        chk_ifid("rst", 32'h0, 32'h0, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);

        // Program load with the pipeline disabled.
        reset = 1'b0;
        load(32'h000, 32'h1111_1111);
        load(32'h004, 32'h2222_2222);
        load(32'h008, 32'h3333_3333);
        load(32'h00C, 32'hFFFF_FFFF);
        load(32'h3FC, 32'h1234_5678);
        chk_ifid("load", 32'h0, 32'h0, 32'h0);

        // Sequential fetch.
        enable = 1'b1;
        step(); chk_ifid("seq0", 32'h1111_1111, 32'd4,  32'd4);
        step(); chk_ifid("seq1", 32'h2222_2222, 32'd8,  32'd8);
        step(); chk_ifid("seq2", 32'h3333_3333, 32'd12, 32'd12);

        // Get back to pc=4 with (11111111,4) in IF/ID.
        jump = 1'b1; jump_addr = 32'h0;
        step(); chk_ifid("jmp0", 32'h0, 32'h0, 32'h0);
        jump = 1'b0;
        step(); chk_ifid("refill", 32'h1111_1111, 32'd4, 32'd4);

        // Stall with a pending branch that must be ignored.
        stall = 1'b1; pc_src = 1'b1; branch_addr = 32'h0;
        step(); chk_ifid("stall0", 32'h1111_1111, 32'd4, 32'd4);
        step(); chk_ifid("stall1", 32'h1111_1111, 32'd4, 32'd4);
        stall = 1'b0; pc_src = 1'b0;
        step(); chk_ifid("unstall", 32'h2222_2222, 32'd8, 32'd8);

        // Branch flush at pc=8.
        pc_src = 1'b1; branch_addr = 32'h0;
        step(); chk_ifid("br", 32'h0, 32'h0, 32'h0);
        pc_src = 1'b0;
        step(); chk_ifid("br_tgt", 32'h1111_1111, 32'd4, 32'd4);

        // Jump beats simultaneous branch.
        pc_src = 1'b1; branch_addr = 32'h0; jump = 1'b1; jump_addr = 32'd8;
        step(); chk_ifid("jmp_wins", 32'h0, 32'h0, 32'd8);
        pc_src = 1'b0; jump = 1'b0;
        step(); chk_ifid("pre_halt", 32'h3333_3333, 32'd12, 32'd12);

        // Halt fetched.
        step(); chk_ifid("halt", 32'hFFFF_FFFF, 32'd16, 32'd12);
        chk("halt_flag", {31'b0, halted}, 32'h1);
        step(); chk_ifid("halt_nop", 32'h0, 32'h0, 32'd12);
        jump = 1'b1; jump_addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_hold", {31'b0, halted}, 32'h1);
            chk("halt_pc", pc, 32'd12);
        end
        jump = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_ifid("rst2", 32'h0, 32'h0, 32'h0);
        chk("rst2_halted", {31'b0, halted}, 32'h0);

        // Write to the word being fetched: old data is fetched.
        imem_we = 1'b1; imem_addr = 32'h0; imem_wdata = 32'hAAAA_AAAA;
        step(); chk_ifid("wr_fetch", 32'h1111_1111, 32'd4, 32'd4);
        imem_we = 1'b0;

        // Index wraps modulo the memory depth.
        jump = 1'b1; jump_addr = 32'h400;
        step(); chk_ifid("wrap_j", 32'h0, 32'h0, 32'h400);
        jump = 1'b0;
        step(); chk_ifid("wrap_f", 32'hAAAA_AAAA, 32'h404, 32'h404);

        // Misaligned target: low bits kept in pc, ignored by fetch.
        jump = 1'b1; jump_addr = 32'h402;
        step(); chk_ifid("mis_j", 32'h0, 32'h0, 32'h402);
        jump = 1'b0;
        step(); chk_ifid("mis_f", 32'hAAAA_AAAA, 32'h406, 32'h406);

        // PC+4 wraps at the top of the address space.
        jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
        step(); chk_ifid("top_j", 32'h0, 32'h0, 32'hFFFF_FFFC);
        jump = 1'b0;
        step(); chk_ifid("top_f", 32'h1234_5678, 32'h0, 32'h0);

        // Disable freezes everything, even a jump.
        enable = 1'b0; jump = 1'b1; jump_addr = 32'h8;
        step(); chk_ifid("frozen", 32'h1234_5678, 32'h0, 32'h0);
        jump = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
